// File: rtl/irrigation_pkg.sv
// ----------------------------------------------------------------------------
// irrigation_pkg
// Shared encodings for the irrigation control chain: tank level codes,
// irrigation type codes, water tank FSM state encodings and error-cause bit
// positions, plus the level-sensor decoder used by the tank controller.
// ----------------------------------------------------------------------------
package irrigation_pkg;

    // Tank level codes (also exported to the display/matrix stages).
    localparam logic [1:0] LVL_EMPTY     = 2'b00;
    localparam logic [1:0] LVL_LOW       = 2'b01;
    localparam logic [1:0] LVL_MID       = 2'b10;
    localparam logic [1:0] LVL_FULL      = 2'b11;

    // Irrigation type codes; 2'b11 is reserved and behaves like off.
    localparam logic [1:0] IRR_OFF       = 2'b00;
    localparam logic [1:0] IRR_DRIP      = 2'b01;
    localparam logic [1:0] IRR_SPRINKLER = 2'b10;

    // Water tank FSM state encodings.
    localparam logic [1:0] ST_STANDBY    = 2'b00;
    localparam logic [1:0] ST_FILLING    = 2'b01;
    localparam logic [1:0] ST_ERROR      = 2'b10;

    // Bit positions inside the error-cause vector.
    localparam int ERR_BIT_SENSOR  = 0;
    localparam int ERR_BIT_TIMEOUT = 1;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } level_t;

    // Sensors are stacked, so only the "filled from the bottom" patterns are
    // physically possible; anything else means a stuck or broken sensor.
    function automatic level_t decode_level(input logic [2:0] hml);
        level_t res;
        res.valid = 1'b1;
        res.code  = LVL_EMPTY;
        case (hml)
            3'b000:  res.code  = LVL_EMPTY;
            3'b001:  res.code  = LVL_LOW;
            3'b011:  res.code  = LVL_MID;
            3'b111:  res.code  = LVL_FULL;
            default: res.valid = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-cycle pulse every TICK_DIV clk cycles.
// Shared with the display multiplexing stages.
//
// Ports:
//   clk    in  system clock, rising edge
//   init   in  synchronous active-low reset
//   tick_o out one-cycle pulse, registered, following the counter wrap
// ----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic init,
    output logic tick_o
);

    localparam int            CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk) begin
        if (!init) begin
            // NOTE: sequential state is always assigned with <= so every flop
            // samples the pre-edge values regardless of statement order.
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick_o = r_tick;

endmodule

// File: rtl/water_tank_controller.sv
// ----------------------------------------------------------------------------
// water_tank_controller
// Drives the tank inlet valve and the sprinkler/drip outlet valves from the
// selected irrigation mode and the three stacked level sensors. Detects
// inconsistent sensor patterns and fill timeouts, latching either into a
// sticky ERROR state that only init clears.
//
// Ports:
//   clk                in  system clock, rising edge
//   init               in  synchronous active-low reset
//   high_level_i       in  water present at the high sensor
//   middle_level_i     in  water present at the middle sensor
//   low_level_i        in  water present at the low sensor
//   irrigation_type_i  in  [1:0] 00 off, 01 drip, 10 sprinkler, 11 off
//   inlet_valve_o      out tank inlet open (FILLING)
//   sprinkler_valve_o  out sprinkler outlet open
//   drip_valve_o       out drip outlet open
//   alarm_o            out tank empty (follows level)
//   error_o            out ERROR state
//   err_cause_o        out [1:0] bit0 sensor inconsistency, bit1 fill timeout
//   level_code_o       out [1:0] 00 empty, 01 low, 10 middle, 11 full
//   state_o            out [1:0] FSM state
// ----------------------------------------------------------------------------
module water_tank_controller
    import irrigation_pkg::*;
#(
    parameter int TICK_DIV       = 50_000_000,
    parameter int FILL_TIMEOUT_S = 30,
    parameter int ERR_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       init,
    input  logic       high_level_i,
    input  logic       middle_level_i,
    input  logic       low_level_i,
    input  logic [1:0] irrigation_type_i,
    output logic       inlet_valve_o,
    output logic       sprinkler_valve_o,
    output logic       drip_valve_o,
    output logic       alarm_o,
    output logic       error_o,
    output logic [1:0] err_cause_o,
    output logic [1:0] level_code_o,
    output logic [1:0] state_o
);

    localparam int               TMR_W   = $clog2(FILL_TIMEOUT_S + 1);
    localparam logic [TMR_W-1:0] TMO_LIM = TMR_W'(FILL_TIMEOUT_S);
    localparam int               INV_W   = $clog2(ERR_CYCLES + 1);
    localparam logic [INV_W-1:0] ERR_LIM = INV_W'(ERR_CYCLES);

    // Two-flop synchronizers; level bits packed as {high, middle, low}.
    logic [2:0]       r_lvl_s1, r_lvl_s2;
    logic [1:0]       r_type_s1, r_type_s2;

    logic [INV_W-1:0] r_inv_cnt;
    logic [TMR_W-1:0] r_fill_tmr;
    logic [1:0]       r_state;
    logic [1:0]       r_err_cause;
    logic [1:0]       r_level;
    logic             r_inlet;
    logic             r_sprinkler;
    logic             r_drip;
    logic             r_alarm;
    logic             r_error;

    logic             w_tick;
    level_t           w_dec;
    logic [1:0]       w_level;
    logic             w_sensor_fault;
    logic             w_timeout;
    logic [1:0]       w_cause_nxt;
    logic [1:0]       w_state_nxt;
    logic             w_sprinkler_nxt;
    logic             w_drip_nxt;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .init   (init),
        .tick_o (w_tick)
    );

    assign w_dec   = decode_level(r_lvl_s2);
    // An invalid pattern keeps the last trusted level so the valves and the
    // display do not chatter while the fault counter decides.
    assign w_level = w_dec.valid ? w_dec.code : r_level;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        w_sensor_fault = (r_inv_cnt >= ERR_LIM);
        // Reaching full in the same evaluation beats the timeout.
        w_timeout      = (r_state == ST_FILLING) && (r_fill_tmr >= TMO_LIM) &&
                         (w_level != LVL_FULL);

        w_cause_nxt                  = r_err_cause;
        w_cause_nxt[ERR_BIT_SENSOR]  = r_err_cause[ERR_BIT_SENSOR]  | w_sensor_fault;
        w_cause_nxt[ERR_BIT_TIMEOUT] = r_err_cause[ERR_BIT_TIMEOUT] | w_timeout;

        w_state_nxt = r_state;
        case (r_state)
            ST_STANDBY: begin
                if (w_cause_nxt != 2'b00)
                    w_state_nxt = ST_ERROR;
                else if (w_level < LVL_MID)
                    w_state_nxt = ST_FILLING;
            end
            ST_FILLING: begin
                // Hysteresis: keep filling through the middle level.
                if (w_cause_nxt != 2'b00)
                    w_state_nxt = ST_ERROR;
                else if (w_level == LVL_FULL)
                    w_state_nxt = ST_STANDBY;
            end
            ST_ERROR:   w_state_nxt = ST_ERROR;
            default:    w_state_nxt = ST_STANDBY;
        endcase

        // Type codes are mutually exclusive, so the outlets can never overlap.
        w_sprinkler_nxt = (r_type_s2 == IRR_SPRINKLER) && (w_level >= LVL_MID) &&
                          (w_state_nxt != ST_ERROR);
        w_drip_nxt      = (r_type_s2 == IRR_DRIP) && (w_level >= LVL_LOW) &&
                          (w_state_nxt != ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!init) begin
            r_lvl_s1    <= 3'b000;
            r_lvl_s2    <= 3'b000;
            r_type_s1   <= 2'b00;
            r_type_s2   <= 2'b00;
            r_inv_cnt   <= '0;
            r_fill_tmr  <= '0;
            r_state     <= ST_STANDBY;
            r_err_cause <= 2'b00;
            r_level     <= LVL_EMPTY;
            r_inlet     <= 1'b0;
            r_sprinkler <= 1'b0;
            r_drip      <= 1'b0;
            r_alarm     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_lvl_s1  <= {high_level_i, middle_level_i, low_level_i};
            r_lvl_s2  <= r_lvl_s1;
            r_type_s1 <= irrigation_type_i;
            r_type_s2 <= r_type_s1;

            // Saturating count of consecutive invalid patterns.
            if (w_dec.valid)
                r_inv_cnt <= '0;
            else if (r_inv_cnt != ERR_LIM)
                r_inv_cnt <= r_inv_cnt + 1'b1;

            // Held at zero outside FILLING so each fill starts a fresh timer.
            if (r_state != ST_FILLING)
                r_fill_tmr <= '0;
            else if (w_tick && (r_fill_tmr != TMO_LIM))
                r_fill_tmr <= r_fill_tmr + 1'b1;

            r_state     <= w_state_nxt;
            r_err_cause <= w_cause_nxt;
            r_level     <= w_level;
            r_inlet     <= (w_state_nxt == ST_FILLING);
            r_sprinkler <= w_sprinkler_nxt;
            r_drip      <= w_drip_nxt;
            r_alarm     <= (w_level == LVL_EMPTY);
            r_error     <= (w_state_nxt == ST_ERROR);
        end
    end

    assign inlet_valve_o     = r_inlet;
    assign sprinkler_valve_o = r_sprinkler;
    assign drip_valve_o      = r_drip;
    assign alarm_o           = r_alarm;
    assign error_o           = r_error;
    assign err_cause_o       = r_err_cause;
    assign level_code_o      = r_level;
    assign state_o           = r_state;

endmodule

// File: tb/tb_water_tank_controller.sv
// ----------------------------------------------------------------------------
// tb_water_tank_controller
// Directed bench for water_tank_controller with TICK_DIV=4, FILL_TIMEOUT_S=3,
// ERR_CYCLES=4. Inputs change and outputs are sampled on the falling edge;
// edge numbers in the comments count rising edges after init is released or
// after the most recent input change.
// Output vector layout: {inlet, sprinkler, drip, alarm, error,
//                        err_cause[1:0], level_code[1:0], state[1:0]}
// ----------------------------------------------------------------------------
module tb_water_tank_controller;

    logic       clk = 1'b0;
    logic       init;
    logic       high_level;
    logic       middle_level;
    logic       low_level;
    logic [1:0] irr_type;
    logic       inlet_valve;
    logic       sprinkler_valve;
    logic       drip_valve;
    logic       alarm;
    logic       error_flag;
    logic [1:0] err_cause;
    logic [1:0] level_code;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    water_tank_controller #(
        .TICK_DIV       (4),
        .FILL_TIMEOUT_S (3),
        .ERR_CYCLES     (4)
    ) dut (
        .clk               (clk),
        .init              (init),
        .high_level_i      (high_level),
        .middle_level_i    (middle_level),
        .low_level_i       (low_level),
        .irrigation_type_i (irr_type),
        .inlet_valve_o     (inlet_valve),
        .sprinkler_valve_o (sprinkler_valve),
        .drip_valve_o      (drip_valve),
        .alarm_o           (alarm),
        .error_o           (error_flag),
        .err_cause_o       (err_cause),
        .level_code_o      (level_code),
        .state_o           (state)
    );

    function automatic logic [10:0] outs();
        return {inlet_valve, sprinkler_valve, drip_valve, alarm, error_flag,
                err_cause, level_code, state};
    endfunction

    task automatic check(input string tag, input logic [10:0] got,
                         input logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (i s d a e cc ll ss)",
                     tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] hml, input logic [1:0] t);
        {high_level, middle_level, low_level} = hml;
        irr_type = t;
    endtask

    // Advance n rising edges, then park on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        init = 1'b0;
        drive(3'b111, 2'b00);
        step(5);
        check("reset_all_zero", outs(), 11'b0_0_0_0_0_00_00_00);
        init = 1'b1;
        step(3);                                            // e3
        check("release_full", outs(), 11'b0_0_0_0_0_00_11_00);

        // ---------------- fill cycle ----------------
        drive(3'b011, 2'b00); step(3);                      // e6
        check("fill_mid_standby", outs(), 11'b0_0_0_0_0_00_10_00);
        drive(3'b001, 2'b00); step(3);                      // e9
        check("fill_start_low", outs(), 11'b1_0_0_0_0_00_01_01);
        drive(3'b011, 2'b00); step(3);                      // e12
        check("fill_hyst_mid", outs(), 11'b1_0_0_0_0_00_10_01);
        drive(3'b111, 2'b00); step(2);                      // e14
        check("fill_full_edge2", outs(), 11'b1_0_0_0_0_00_10_01);
        step(1);                                            // e15
        check("fill_full_stop", outs(), 11'b0_0_0_0_0_00_11_00);

        // ---------------- mode gating ----------------
        init = 1'b0; drive(3'b111, 2'b00); step(2);
        init = 1'b1; step(3);                               // e3 standby, full
        drive(3'b011, 2'b10); step(3);                      // e6
        check("gate_spr_mid", outs(), 11'b0_1_0_0_0_00_10_00);
        drive(3'b001, 2'b10); step(3);                      // e9, filling
        check("gate_spr_low", outs(), 11'b1_0_0_0_0_00_01_01);
        drive(3'b001, 2'b01); step(3);                      // e12
        check("gate_drip_low", outs(), 11'b1_0_1_0_0_00_01_01);
        drive(3'b000, 2'b01); step(3);                      // e15
        check("gate_drip_empty", outs(), 11'b1_0_0_1_0_00_00_01);
        drive(3'b011, 2'b11); step(3);                      // e18, timer at 2
        check("gate_reserved", outs(), 11'b1_0_0_0_0_00_10_01);
        init = 1'b0; step(1);
        check("reset_mid_fill", outs(), 11'b0_0_0_0_0_00_00_00);

        // ---------------- sensor fault ----------------
        drive(3'b111, 2'b10); step(1);
        init = 1'b1; step(3);                               // e3 standby, full
        check("sens_base", outs(), 11'b0_1_0_0_0_00_11_00);
        drive(3'b101, 2'b10); step(3);
        drive(3'b111, 2'b10); step(6);
        check("sens_glitch_ok", outs(), 11'b0_1_0_0_0_00_11_00);
        drive(3'b101, 2'b10); step(6);                      // 6 edges after change
        check("sens_err_edge6", outs(), 11'b0_1_0_0_0_00_11_00);
        step(1);                                            // 7 edges after change
        check("sens_err_edge7", outs(), 11'b0_0_0_0_1_01_11_10);
        drive(3'b000, 2'b10); step(5);
        check("sens_err_sticky", outs(), 11'b0_0_0_1_1_01_00_10);
        init = 1'b0; step(1);
        check("sens_err_cleared", outs(), 11'b0_0_0_0_0_00_00_00);

        // ---------------- fill timeout ----------------
        drive(3'b001, 2'b00); step(1);
        init = 1'b1; step(13);                              // e13, timer hits 3
        check("tmo_before", outs(), 11'b1_0_0_0_0_00_01_01);
        step(1);                                            // e14
        check("tmo_error", outs(), 11'b0_0_0_0_1_10_01_10);

        // ---------------- simultaneous causes ----------------
        init = 1'b0; drive(3'b001, 2'b00); step(2);
        init = 1'b1; step(7);                               // e7
        drive(3'b101, 2'b00); step(6);                      // e13, count 4, timer 3
        check("both_before", outs(), 11'b1_0_0_0_0_00_01_01);
        step(1);                                            // e14
        check("both_causes", outs(), 11'b0_0_0_0_1_11_01_10);

        // ---------------- full on the timeout tick ----------------
        init = 1'b0; drive(3'b001, 2'b00); step(2);
        init = 1'b1; step(10);                              // e10
        drive(3'b111, 2'b00); step(2);                      // e12
        check("full_tick_pre", outs(), 11'b1_0_0_0_0_00_01_01);
        step(1);                                            // e13, tick + full
        check("full_tick_standby", outs(), 11'b0_0_0_0_0_00_11_00);
        step(4);                                            // e17
        check("full_tick_no_err", outs(), 11'b0_0_0_0_0_00_11_00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
